// File: rtl/palette_ram_fade.sv
// Runtime-writable colour palette: index -> RGB through a 2-stage registered
// pipeline with per-pixel brightness fade and transparency-key detection.
module palette_ram_fade #(
  parameter int INDEX_W      = 9,
  parameter int COLOR_W      = 4,
  parameter int FADE_W       = 4,
  parameter int TRANSP_INDEX = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_valid,
  input  logic [INDEX_W-1:0]     rd_index,
  input  logic [FADE_W-1:0]      fade,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [3*COLOR_W-1:0]   wr_color,
  output logic                   out_valid,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  output logic                   busy
);

  localparam int DEPTH  = 1 << INDEX_W;
  localparam int PROD_W = COLOR_W + FADE_W + 1;

  typedef enum logic {INIT, IDLE} state_t;

  state_t               state;
  logic [INDEX_W-1:0]   init_cnt;

  logic [3*COLOR_W-1:0] mem [DEPTH];
  logic                 mem_we;
  logic [INDEX_W-1:0]   mem_waddr;
  logic [3*COLOR_W-1:0] mem_wdata;

  logic                 s1_valid;
  logic                 s1_transp;
  logic [3*COLOR_W-1:0] s1_color;
  logic [FADE_W-1:0]    s1_fade;

  // ch * (fade + 1) >> FADE_W, wide enough that fade = all-ones is exact identity.
  function automatic logic [COLOR_W-1:0] fade_ch(input logic [COLOR_W-1:0] ch,
                                                  input logic [FADE_W-1:0]  f);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(ch) * (PROD_W'(f) + PROD_W'(1));
    return COLOR_W'(prod >> FADE_W);
  endfunction

  // The init sequencer owns the write port until every entry has been cleared.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    mem_we    = 1'b0;
    mem_waddr = wr_index;
    mem_wdata = wr_color;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = '0;
    end else if (wr_valid && wr_ready) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset branch so it maps onto block RAM; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + INDEX_W'(1);
          if (init_cnt == INDEX_W'(DEPTH - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end
        end
        IDLE: begin
          busy     <= 1'b0;
          wr_ready <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: non-blocking reads sample mem before this edge's write lands, giving read-first collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_color  <= '0;
      s1_fade   <= '0;
    end else begin
      s1_valid  <= rd_valid;
      s1_transp <= (rd_index == INDEX_W'(TRANSP_INDEX));
      s1_color  <= mem[rd_index];
      s1_fade   <= fade;
    end
  end

  // Colour and key hold their last values across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        red         <= fade_ch(s1_color[3*COLOR_W-1 -: COLOR_W], s1_fade);
        green       <= fade_ch(s1_color[2*COLOR_W-1 -: COLOR_W], s1_fade);
        blue        <= fade_ch(s1_color[COLOR_W-1 -: COLOR_W],   s1_fade);
        transparent <= s1_transp;
      end
    end
  end

endmodule

// File: tb/tb_palette_ram_fade.sv
// Self-checking bench for palette_ram_fade: behavioural palette model compared
// every cycle, plus hand-computed lookups pinning INIT, fade, collision and reset.
module tb_palette_ram_fade;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_valid = 1'b0;
  logic [8:0]  rd_index = '0;
  logic [3:0]  fade = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [8:0]  wr_index = '0;
  logic [11:0] wr_color = '0;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  palette_ram_fade dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_index(rd_index), .fade(fade),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_color(wr_color),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .transparent(transparent), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] mmem [512];
  int unsigned m_cnt;
  bit          m_busy;
  bit          req_v, req_t, e_v, e_t;
  logic [11:0] req_col, e_col;

  function automatic logic [11:0] faded(input logic [11:0] c, input int f);
    int r, g, b;
    r = (int'(c[11:8]) * (f + 1)) / 16;
    g = (int'(c[7:4])  * (f + 1)) / 16;
    b = (int'(c[3:0])  * (f + 1)) / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  initial foreach (mmem[i]) mmem[i] = '0;

  // Lookup taken at one edge appears at the next; the palette is read before this edge's write.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_busy = 1'b1;
      req_v = 1'b0; req_t = 1'b0; req_col = '0;
      e_v = 1'b0; e_t = 1'b0; e_col = '0;
    end else begin
      e_v = req_v;
      if (req_v) begin
        e_col = req_col;
        e_t   = req_t;
      end
      req_v   = rd_valid;
      req_col = faded(mmem[rd_index], int'(fade));
      req_t   = (rd_index == 9'd0);
      if (m_busy) begin
        mmem[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == 512) m_busy = 1'b0;
      end else if (wr_valid) begin
        mmem[wr_index] = wr_color;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst)
      check("cycle", {16'd0, out_valid, red, green, blue, transparent, busy, wr_ready},
                     {16'd0, e_v, e_col, e_t, m_busy, !m_busy});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic release_and_count(input string name);
    int cnt;
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      tick();
    end
    check(name, cnt, 512);
    check({name, "_ready"}, wr_ready, 1);
  endtask

  task automatic write(input logic [8:0] idx, input logic [11:0] col);
    wr_valid = 1'b1; wr_index = idx; wr_color = col;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [8:0] idx, input logic [3:0] f,
                        input logic [11:0] exp_col, input logic exp_t);
    rd_valid = 1'b1; rd_index = idx; fade = f;
    tick();
    rd_valid = 1'b0;
    tick();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_rgb"}, {red, green, blue}, exp_col);
    check({name, "_transp"}, transparent, exp_t);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(); tick();
    release_and_count("init_len");
    lookup("post_init_300", 9'd300, 4'hF, 12'h000, 1'b0);

    write(9'd5, 12'hF82);
    lookup("rd5_fF", 9'd5, 4'hF, 12'hF82, 1'b0);
    lookup("rd5_f7", 9'd5, 4'h7, 12'h741, 1'b0);
    lookup("rd5_f0", 9'd5, 4'h0, 12'h000, 1'b0);

    // Same-cycle write and read of entry 9 returns the old contents.
    wr_valid = 1'b1; wr_index = 9'd9; wr_color = 12'h123;
    rd_valid = 1'b1; rd_index = 9'd9; fade = 4'hF;
    tick();
    wr_valid = 1'b0;
    tick();
    rd_valid = 1'b0;
    check("collide_old", {red, green, blue}, 12'h000);
    tick();
    check("collide_new", {red, green, blue}, 12'h123);

    // Gapped lookups 0, (5), 0.
    rd_valid = 1'b1; rd_index = 9'd0; fade = 4'hF;
    tick();
    rd_valid = 1'b0; rd_index = 9'd5;
    tick();
    check("gap_v0", out_valid, 1);
    check("gap_t0", transparent, 1);
    rd_valid = 1'b1; rd_index = 9'd0;
    tick();
    rd_valid = 1'b0;
    check("gap_v1", out_valid, 0);
    tick();
    check("gap_v2", out_valid, 1);
    check("gap_t2", transparent, 1);

    // Random traffic on a small index window to force collisions.
    for (int i = 0; i < 2000; i++) begin
      rd_valid = ($urandom % 4) != 0;
      rd_index = 9'($urandom_range(0, 15));
      fade     = 4'($urandom);
      wr_valid = $urandom % 2;
      wr_index = 9'($urandom_range(0, 15));
      wr_color = 12'($urandom);
      tick();
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    write(9'd400, 12'hABC);

    // Reset, then read a not-yet-cleared entry during INIT, then reset again mid-INIT.
    #2 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wr_valid = 1'b1; wr_index = 9'd7; wr_color = 12'hFFF;
    for (int i = 0; i < 50; i++) tick();
    rd_valid = 1'b1; rd_index = 9'd400; fade = 4'hF;
    tick();
    rd_valid = 1'b0;
    tick();
    check("init_read_400", {red, green, blue}, 12'hABC);
    for (int i = 0; i < 48; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("async_clear", {out_valid, red, green, blue, transparent}, 14'd0);
    check("async_busy", {busy, wr_ready}, 2'b10);
    tick(); tick();
    release_and_count("reinit_len");
    wr_valid = 1'b0;
    lookup("init_write_ignored", 9'd7, 4'hF, 12'h000, 1'b0);
    lookup("reinit_400", 9'd400, 4'hF, 12'h000, 1'b0);
    lookup("rd0_key", 9'd0, 4'h3, 12'h000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/palette_ram_fade.md
Name: palette_ram_fade

Overview:
- Parametrised, runtime-writable successor to the fixed sprite palette ROMs.
- Maps a pixel colour index to RGB through a registered 2-stage pipeline, with per-pixel brightness fade and transparency-key detection.
- Sits between the sprite/background index fetch and the VGA colour mux.
- After reset, an init sequencer clears every entry to black. Game logic then loads palettes through a valid/ready write port.

Parameters:
- INDEX_W, 9, palette index width; depth DEPTH = 2^INDEX_W.
- COLOR_W, 4, bits per colour channel.
- FADE_W, 4, fade control width; all-ones = full brightness.
- TRANSP_INDEX, 0, index flagged as transparent.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- rd_valid  in  1  lookup request this cycle.
- rd_index  in  INDEX_W  colour index to look up.
- fade  in  FADE_W  brightness, sampled with rd_index.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_index  in  INDEX_W  entry to write.
- wr_color  in  3*COLOR_W  {red, green, blue}, red in the MSBs.
- out_valid  out  1  red/green/blue/transparent are valid.
- red  out  COLOR_W  faded red.
- green  out  COLOR_W  faded green.
- blue  out  COLOR_W  faded blue.
- transparent  out  1  output pixel's index equals TRANSP_INDEX.
- busy  out  1  init sequencer active.

Behaviour:
- Reset (asynchronous):
  - Clears out_valid, red, green, blue, transparent and both pipeline stages to 0.
  - Sets busy=1 and wr_ready=0, and enters state INIT with init counter = 0.
  - Memory contents are not cleared by reset itself; the INIT sequence clears them.
- FSM, states INIT and IDLE:
  - INIT: each cycle writes 0 to entry init_cnt, then increments init_cnt.
  - When init_cnt = DEPTH-1 has been written, the next state is IDLE.
  - INIT lasts exactly DEPTH cycles after Reset deasserts. busy is high throughout and drops on the first IDLE cycle.
  - IDLE: busy=0 and wr_ready=1. There is no return to INIT except via Reset.
- Writes:
  - Accepted only in IDLE; wr_valid is ignored while wr_ready=0.
  - One write per cycle, zero back-pressure in IDLE.
  - An accepted write updates the memory at the clock edge.
- Read pipeline (runs in both states; reads during INIT return whatever the entry holds, cleared or not):
  - Stage 1 (edge 1): registers mem[rd_index], fade, rd_valid, and (rd_index == TRANSP_INDEX).
  - Stage 2 (edge 2): registers the faded colour, out_valid and transparent.
  - Latency is exactly 2 cycles from rd_valid to out_valid. Throughput is 1 lookup per cycle; there is no stall.
  - When rd_valid=0 the bubble propagates (out_valid=0). red/green/blue/transparent hold their last values when out_valid=0.
- Read/write collision: same index in the same cycle is read-first; the lookup returns the pre-write value.
- Fade arithmetic:
  - ch_out = (ch * (fade + 1)) >> FADE_W, computed at COLOR_W+FADE_W+1 bits and truncated to COLOR_W. No rounding.
  - fade = 2^FADE_W - 1 gives the identity; fade = 0 gives ch >> FADE_W (0 when COLOR_W <= FADE_W).
- Transparency: transparent is a pure index compare carried through the pipeline. It is independent of colour and fade.
- Reset mid-INIT or mid-IDLE: pipeline contents are discarded and INIT restarts from entry 0 with the full DEPTH cycles.

Test Plan (INIT/write/lookup cases use defaults INIT/write/lookup cases use defaults INDEX_W=9, COLOR_W=4, FADE_W=4, TRANSP_INDEX=0):
- Reset pulse then release -> busy=1 and wr_ready=0 for exactly 512 cycles; busy=0 and wr_ready=1 on cycle 513; lookup of index 300 afterwards returns 0,0,0.
- IDLE write idx 5 = {F,8,2}, then rd_valid with idx 5 and fade F -> out_valid 2 cycles later with red=F, green=8, blue=2, transparent=0.
- Read idx 5 with fade 7 -> 7,4,1; with fade 0 -> 0,0,0.
- Same-cycle write idx 9 = {1,2,3} and read idx 9 -> 0,0,0 returned; read next cycle -> 1,2,3.
- Back-to-back reads idx 0,5,0 with rd_valid gapped (1,0,1) -> out_valid pattern 1,0,1; transparent=1 for both idx-0 results.
- Reset asserted at INIT cycle 100 -> outputs cleared immediately (asynchronous); busy stays high for a full 512 cycles after release; writes issued during INIT are not applied.
